// File: rtl/clarvi_regfile_banked.sv
// Banked integer register file: PARTS independent part-wide banks, registered reads, post-reset clear sequencer.
// Define REGFILE_BYPASS_EN to forward a same-edge write to a matching read; otherwise collisions read the old value.
module clarvi_regfile_banked #(
    parameter int REG_WIDTH  = 64,
    parameter int PART_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int DEBUG_REG  = 28,
    localparam int PARTS     = REG_WIDTH / PART_WIDTH,
    localparam int PS_W      = (PARTS > 1) ? $clog2(PARTS) : 1,
    localparam int IX_W      = $clog2(NUM_REGS)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [IX_W-1:0]       rd1_reg,
    input  logic [PS_W-1:0]       rd1_part,
    input  logic [IX_W-1:0]       rd2_reg,
    input  logic [PS_W-1:0]       rd2_part,
    input  logic                  rd2_part_override,
    output logic [PART_WIDTH-1:0] rd1_data,
    output logic [PART_WIDTH-1:0] rd2_data,
    input  logic                  wr_enable,
    input  logic [IX_W-1:0]       wr_reg,
    input  logic [PS_W-1:0]       wr_part,
    input  logic [PART_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic [REG_WIDTH-1:0]  debug_data
);

    typedef enum logic {CLEAR, READY} state_t;

    state_t                state;
    logic [IX_W-1:0]       clr_idx;
    logic [PART_WIDTH-1:0] mem [PARTS][NUM_REGS];

    logic                  wr_ok;
    logic [PS_W-1:0]       rd2_part_eff;
    logic [PART_WIDTH-1:0] rd1_word;
    logic [PART_WIDTH-1:0] rd2_word;

    assign wr_ok = wr_enable && (state == READY) && (wr_reg != '0) && (int'(wr_part) < PARTS);
    assign rd2_part_eff = rd2_part_override ? '0 : rd2_part;

    // Out-of-range parts and x0 fall through to the zero default.
    always_comb begin
        rd1_word = '0;
        rd2_word = '0;
        for (int p = 0; p < PARTS; p++) begin
            if (int'(rd1_part) == p && rd1_reg != '0)
                rd1_word = mem[p][rd1_reg];
            if (int'(rd2_part_eff) == p && rd2_reg != '0)
                rd2_word = mem[p][rd2_reg];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && wr_reg == rd1_reg && wr_part == rd1_part)
            rd1_word = wr_data;
        if (wr_ok && wr_reg == rd2_reg && wr_part == rd2_part_eff)
            rd2_word = wr_data;
`endif
    end

    // Storage carries no reset so it can map onto block RAM; the sequencer zeroes it.
    always_ff @(posedge clock) begin
        for (int p = 0; p < PARTS; p++) begin
            if (state == CLEAR)
                mem[p][clr_idx] <= '0;
            else if (wr_ok && int'(wr_part) == p)
                mem[p][wr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CLEAR;
            clr_idx    <= '0;
            busy       <= 1'b1;
            rd1_data   <= '0;
            rd2_data   <= '0;
            debug_data <= '0;
        end else if (state == CLEAR) begin
            clr_idx    <= clr_idx + 1'b1;
            rd1_data   <= '0;
            rd2_data   <= '0;
            debug_data <= '0;
            if (clr_idx == IX_W'(NUM_REGS - 1)) begin
                state <= READY;
                busy  <= 1'b0;
            end
        end else begin
            rd1_data <= rd1_word;
            rd2_data <= rd2_word;
            if (wr_ok && wr_reg == IX_W'(DEBUG_REG)) begin
                for (int p = 0; p < PARTS; p++)
                    if (int'(wr_part) == p)
                        debug_data[p*PART_WIDTH +: PART_WIDTH] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_clarvi_regfile_banked.sv
// Directed bench for clarvi_regfile_banked with a register-array model checked every falling edge.
module tb_clarvi_regfile_banked;

    localparam int NR = 32;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  rd1_reg = '0;
    logic        rd1_part = '0;
    logic [4:0]  rd2_reg = '0;
    logic        rd2_part = '0;
    logic        rd2_part_override = 1'b0;
    logic [31:0] rd1_data;
    logic [31:0] rd2_data;
    logic        wr_enable = 1'b0;
    logic [4:0]  wr_reg = '0;
    logic        wr_part = '0;
    logic [31:0] wr_data = '0;
    logic        busy;
    logic [63:0] debug_data;

    clarvi_regfile_banked dut (
        .clock(clock), .reset_n(reset_n),
        .rd1_reg(rd1_reg), .rd1_part(rd1_part),
        .rd2_reg(rd2_reg), .rd2_part(rd2_part),
        .rd2_part_override(rd2_part_override),
        .rd1_data(rd1_data), .rd2_data(rd2_data),
        .wr_enable(wr_enable), .wr_reg(wr_reg), .wr_part(wr_part), .wr_data(wr_data),
        .busy(busy), .debug_data(debug_data)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Model: registers as a 2-D array, busy as a count of edges since reset.
    logic [31:0] mdl [NR][2];
    int          n_edges;
    logic [31:0] e_rd1, e_rd2;
    logic [63:0] e_dbg;
    logic        m_p2, m_acc;

    function automatic logic [31:0] mread(input logic [4:0] r, input logic p);
        return (r == 0) ? 32'h0 : mdl[r][p];
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            n_edges = 0;
            e_rd1 = 0;
            e_rd2 = 0;
            e_dbg = 0;
        end else if (n_edges < NR) begin
            mdl[n_edges][0] = 0;
            mdl[n_edges][1] = 0;
            e_rd1 = 0;
            e_rd2 = 0;
            e_dbg = 0;
            n_edges++;
        end else begin
            m_p2  = rd2_part_override ? 1'b0 : rd2_part;
            m_acc = wr_enable && (wr_reg != 0);
            e_rd1 = mread(rd1_reg, rd1_part);
            e_rd2 = mread(rd2_reg, m_p2);
`ifdef REGFILE_BYPASS_EN
            if (m_acc && wr_reg == rd1_reg && wr_part == rd1_part) e_rd1 = wr_data;
            if (m_acc && wr_reg == rd2_reg && wr_part == m_p2)     e_rd2 = wr_data;
`endif
            if (m_acc) mdl[wr_reg][wr_part] = wr_data;
            e_dbg = {mdl[28][1], mdl[28][0]};
        end
    end

    always @(negedge clock) begin
        chk("rd1_data", {32'h0, rd1_data}, {32'h0, e_rd1});
        chk("rd2_data", {32'h0, rd2_data}, {32'h0, e_rd2});
        chk("busy", {63'h0, busy}, {63'h0, n_edges < NR});
        chk("debug_data", debug_data, e_dbg);
    end

    task automatic step(input logic we, input logic [4:0] wr, input logic wp, input logic [31:0] wd,
                        input logic [4:0] r1, input logic p1, input logic [4:0] r2, input logic p2,
                        input logic ov);
        wr_enable = we; wr_reg = wr; wr_part = wp; wr_data = wd;
        rd1_reg = r1; rd1_part = p1; rd2_reg = r2; rd2_part = p2; rd2_part_override = ov;
        @(negedge clock);
    endtask

    task automatic run_clear(input string tag);
        for (int k = 1; k <= NR; k++) begin
            step(1'b1, 5'd5, 1'b0, 32'h1, 5'd7, 1'b0, 5'd5, 1'b0, 1'b0);
            chk({tag, "_rd_forced0"}, {32'h0, rd1_data}, 64'h0);
            if (k == NR - 1) chk({tag, "_busy_edge31"}, {63'h0, busy}, 64'h1);
            if (k == NR)     chk({tag, "_busy_edge32"}, {63'h0, busy}, 64'h0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("reset_busy", {63'h0, busy}, 64'h1);
        chk("reset_dbg", debug_data, 64'h0);
        reset_n = 1'b1;
        run_clear("clr");
        step(0, 0, 0, 0, 5'd5, 0, 5'd5, 1, 0);
        chk("x5_after_clear", {32'h0, rd1_data}, 64'h0);

        step(1, 5'd7, 0, 32'hDEADBEEF, 5'd7, 0, 5'd7, 1, 0);
        chk("x7p1_untouched_a", {32'h0, rd2_data}, 64'h0);
        step(1, 5'd7, 1, 32'h01234567, 5'd7, 0, 5'd7, 1, 0);
        chk("x7p0_after_p1_wr", {32'h0, rd1_data}, 64'hDEADBEEF);
        step(0, 0, 0, 0, 5'd7, 0, 5'd7, 1, 0);
        chk("x7p0", {32'h0, rd1_data}, 64'hDEADBEEF);
        chk("x7p1", {32'h0, rd2_data}, 64'h01234567);

        step(1, 5'd0, 0, 32'hFFFFFFFF, 5'd0, 0, 5'd0, 1, 0);
        chk("x0_same_edge", {32'h0, rd1_data}, 64'h0);
        step(0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 0);
        chk("x0_read", {32'h0, rd1_data}, 64'h0);
        step(0, 0, 0, 0, 5'd7, 1, 5'd7, 1, 1);
        chk("override", {32'h0, rd2_data}, 64'hDEADBEEF);
        chk("no_override_rd1", {32'h0, rd1_data}, 64'h01234567);

        step(1, 5'd9, 1, 32'hCAFEF00D, 5'd9, 1, 5'd9, 0, 0);
`ifdef REGFILE_BYPASS_EN
        chk("collision", {32'h0, rd1_data}, 64'hCAFEF00D);
`else
        chk("collision", {32'h0, rd1_data}, 64'h0);
`endif
        chk("x9p0", {32'h0, rd2_data}, 64'h0);
        step(0, 0, 0, 0, 5'd9, 1, 5'd9, 0, 0);
        chk("x9p1_after", {32'h0, rd1_data}, 64'hCAFEF00D);

        step(1, 5'd28, 1, 32'hAAAA5555, 5'd7, 0, 5'd9, 1, 0);
        chk("dbg_hi", debug_data, 64'hAAAA5555_00000000);
        step(1, 5'd28, 0, 32'h12345678, 5'd7, 0, 5'd9, 1, 0);
        chk("dbg_full", debug_data, 64'hAAAA5555_12345678);
        chk("x7p0_again", {32'h0, rd1_data}, 64'hDEADBEEF);

        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_busy", {63'h0, busy}, 64'h1);
        chk("async_rst_rd1", {32'h0, rd1_data}, 64'h0);
        chk("async_rst_dbg", debug_data, 64'h0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 5'd7, 0, 5'd9, 1, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("midclr_busy", {63'h0, busy}, 64'h1);
        @(negedge clock);
        reset_n = 1'b1;
        run_clear("clr2");
        step(0, 0, 0, 0, 5'd7, 0, 5'd28, 1, 0);
        chk("x7_recleared", {32'h0, rd1_data}, 64'h0);
        chk("x28_recleared", {32'h0, rd2_data}, 64'h0);
        chk("dbg_recleared", debug_data, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
